// File: rtl/alu_exec_stage_pkg.sv
// ============================================================================
//  Module   : alu_exec_stage_pkg
//  Purpose  : Opcodes, FSM state encodings and result-flag type for the
//             alu execute stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_exec_stage_pkg;

   localparam logic [2:0] OC_ADD = 3'b000;
   localparam logic [2:0] OC_SUB = 3'b001;
   localparam logic [2:0] OC_MUL = 3'b010;
   localparam logic [2:0] OC_DIV = 3'b011;
   localparam logic [2:0] OC_NOT = 3'b100;
   localparam logic [2:0] OC_XOR = 3'b101;
   localparam logic [2:0] OC_OR  = 3'b110;
   localparam logic [2:0] OC_AND = 3'b111;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef struct packed {
      logic zero;
      logic neg;
      logic dz;
   } flags_t;

endpackage

`default_nettype wire

// File: rtl/alu_exec_stage_alu.sv
// ============================================================================
//  Module   : alu
//  Purpose  : Combinational unsigned alu (add/sub/mul/div/not/xor/or/and).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
   import alu_exec_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic [2:0]            i_oc,
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   output logic [DATA_WIDTH-1:0] o_f
);

   always_comb begin
      o_f = '0;
      case (i_oc)
         OC_ADD: o_f = i_a + i_b;
         OC_SUB: o_f = i_a - i_b;
         OC_MUL: o_f = i_a * i_b;
         // Zero divisor yields a defined value; the stage overrides it anyway.
         OC_DIV: o_f = (i_b == '0) ? '1 : i_a / i_b;
         OC_NOT: o_f = ~i_a;
         OC_XOR: o_f = i_a ^ i_b;
         OC_OR:  o_f = i_a | i_b;
         OC_AND: o_f = i_a & i_b;
         default: o_f = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/alu_exec_stage.sv
// ============================================================================
//  Module   : alu_exec_stage
//  Purpose  : Registered execute stage around the alu with valid/ready
//             handshakes on both sides and zero/neg/divide-by-zero flags.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_stage
   import alu_exec_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_oc,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_f,
   output logic                  out_zero,
   output logic                  out_neg,
   output logic                  out_dz
);

   localparam int HIGH = DATA_WIDTH - 1;

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [2:0]    r_oc;
   logic [HIGH:0] r_a;
   logic [HIGH:0] r_b;
   logic [HIGH:0] r_f;
   flags_t        r_flags;
   logic [HIGH:0] w_alu_f;
   logic [HIGH:0] w_f_fin;
   logic          w_dz;
   logic          w_accept;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (in_valid) w_state_nxt = S_EXEC;
         S_EXEC: w_state_nxt = S_DONE;
         S_DONE: if (out_ready) w_state_nxt = in_valid ? S_EXEC : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         S_IDLE: in_ready = 1'b1;
         S_DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   assign w_accept = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_oc <= '0;
         r_a  <= '0;
         r_b  <= '0;
      end else if (w_accept) begin
         r_oc <= in_oc;
         r_a  <= in_a;
         r_b  <= in_b;
      end
   end

   alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
      .i_oc (r_oc),
      .i_a  (r_a),
      .i_b  (r_b),
      .o_f  (w_alu_f)
   );

   // Divide by zero forces all ones; flags follow the final value.
   assign w_dz    = (r_oc == OC_DIV) && (r_b == '0);
   assign w_f_fin = w_dz ? '1 : w_alu_f;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_f     <= '0;
         r_flags <= '0;
      end else if (r_state == S_EXEC) begin
         r_f          <= w_f_fin;
         r_flags.zero <= (w_f_fin == '0);
         r_flags.neg  <= w_f_fin[HIGH];
         r_flags.dz   <= w_dz;
      end
   end

   assign out_f    = r_f;
   assign out_zero = r_flags.zero;
   assign out_neg  = r_flags.neg;
   assign out_dz   = r_flags.dz;

endmodule

`default_nettype wire
